// File: rtl/istream_pack_buffer_if.sv
// Handshake and status bundle for istream_pack_buffer.
// Input beat stream, packed output stream and buffer occupancy status.
interface istream_pack_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK_RATIO = 2,
  parameter int DEPTH      = 8
);
  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam int LW = $clog2(DEPTH + 1);

  logic                  istream_valid;
  logic [DATA_WIDTH-1:0] istream_data;
  logic                  istream_last;
  logic                  istream_ready;
  logic                  istream_flush;

  logic                  ostream_valid;
  logic [WW-1:0]         ostream_data;
  logic                  ostream_last;
  logic                  ostream_ready;

  logic                  istream_buff_full;
  logic                  istream_buff_empty;
  logic                  istream_buff_afull;
  logic [LW-1:0]         istream_buff_level;

  modport master (
    output istream_valid,
    output istream_data,
    output istream_last,
    output istream_flush,
    output ostream_ready,
    input  istream_ready,
    input  ostream_valid,
    input  ostream_data,
    input  ostream_last,
    input  istream_buff_full,
    input  istream_buff_empty,
    input  istream_buff_afull,
    input  istream_buff_level
  );

  modport slave (
    input  istream_valid,
    input  istream_data,
    input  istream_last,
    input  istream_flush,
    input  ostream_ready,
    output istream_ready,
    output ostream_valid,
    output ostream_data,
    output ostream_last,
    output istream_buff_full,
    output istream_buff_empty,
    output istream_buff_afull,
    output istream_buff_level
  );
endinterface

// File: rtl/istream_pack_buffer.sv
// Packs PACK_RATIO input beats into one wide word and queues
// the words in a first-word-fall-through buffer.
module istream_pack_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int PACK_RATIO   = 2,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input logic istream_clk,
  input logic istream_rst,
  istream_pack_buffer_if.slave bus
);
  localparam int WW = DATA_WIDTH * PACK_RATIO;
  localparam int CW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic          rdy_en_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] acc_q, acc_d;
  logic [WW-1:0] word;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [WW:0]   mem_q [DEPTH];

  logic full, empty, push, pop, close, flush;

  assign flush = bus.istream_flush;
  assign full  = (lvl_q == LW'(DEPTH));
  assign empty = (lvl_q == '0);
  assign push  = bus.istream_valid && bus.istream_ready;
  assign pop   = !empty && bus.ostream_ready;
  assign close = push &&
    ((cnt_q == CW'(PACK_RATIO - 1)) || bus.istream_last);

  assign bus.istream_ready = rdy_en_q && !full && !flush;

  // Lanes above the current beat are still zero in acc_q.
  always_comb begin
    word = acc_q;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        word[k*DATA_WIDTH +: DATA_WIDTH] = bus.istream_data;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (close) begin
        cnt_d = '0;
        acc_d = '0;
        wr_d  = wr_q + PW'(1);
      end else if (push) begin
        cnt_d = cnt_q + CW'(1);
        acc_d = word;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      if (close && !pop) begin
        lvl_d = lvl_q + LW'(1);
      end else if (!close && pop) begin
        lvl_d = lvl_q - LW'(1);
      end
    end
  end

  always_ff @(posedge istream_clk or posedge istream_rst) begin
    if (istream_rst) begin
      rdy_en_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      lvl_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge istream_clk) begin
    if (close && !flush) begin
      mem_q[wr_q] <= {bus.istream_last, word};
    end
  end

  // Storage is never cleared; gating on empty gives zeroed outputs.
  assign bus.ostream_valid = !empty;
  assign {bus.ostream_last, bus.ostream_data} =
    empty ? '0 : mem_q[rd_q];

  assign bus.istream_buff_full  = full;
  assign bus.istream_buff_empty = empty;
  assign bus.istream_buff_afull = (lvl_q >= LW'(AFULL_THRESH));
  assign bus.istream_buff_level = lvl_q;
endmodule

// File: tb/tb_istream_pack_buffer.sv
// Bench for istream_pack_buffer: directed scenarios plus random
// traffic against a queue-based packing/buffering model.
module tb_istream_pack_buffer;
  localparam int DW    = 32;
  localparam int PR    = 2;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int WW    = DW * PR;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  istream_pack_buffer_if #(
    .DATA_WIDTH(DW), .PACK_RATIO(PR), .DEPTH(DEPTH)
  ) bus ();

  istream_pack_buffer #(
    .DATA_WIDTH(DW), .PACK_RATIO(PR),
    .DEPTH(DEPTH), .AFULL_THRESH(AF)
  ) dut (
    .istream_clk(clk),
    .istream_rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WW:0]   exp_q [$];
  logic [WW:0]   popped [$];
  logic [WW:0]   got [$];
  logic [DW-1:0] pend [$];
  bit            out_of_rst = 1'b0;
  bit            took = 1'b0;

  // Advance one clock and update the model with the values
  // presented to the design at that edge.
  task automatic tick();
    bit rdy, psh, pp, fl, lst;
    logic [DW-1:0] d;
    logic [WW:0] w;
    fl  = bus.istream_flush;
    d   = bus.istream_data;
    lst = bus.istream_last;
    rdy = out_of_rst && (exp_q.size() < DEPTH) && !fl;
    psh = bus.istream_valid && rdy;
    pp  = (exp_q.size() > 0) && bus.ostream_ready;
    if (!fl && bus.ostream_valid && bus.ostream_ready)
      got.push_back({bus.ostream_last, bus.ostream_data});
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      pend.delete();
    end else begin
      if (pp) popped.push_back(exp_q.pop_front());
      if (psh) begin
        pend.push_back(d);
        if (pend.size() == PR || lst) begin
          w = '0;
          for (int k = 0; k < pend.size(); k++)
            w[k*DW +: DW] = pend[k];
          w[WW] = lst;
          exp_q.push_back(w);
          pend.delete();
        end
      end
    end
    out_of_rst = 1'b1;
    took = psh;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bus.istream_valid = 1'b1;
    bus.istream_data  = d;
    bus.istream_last  = l;
    do begin
      tick();
      n++;
    end while (!took && n < 64);
    bus.istream_valid = 1'b0;
    bus.istream_last  = 1'b0;
    checks++;
    if (!took) begin
      errors++;
      $display("FAIL send_timeout beat=%h not accepted in %0d cycles",
               d, n);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.istream_ready !== 1'b0 || bus.ostream_valid !== 1'b0 ||
        bus.ostream_data !== '0 || bus.ostream_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out rdy=%b v=%b d=%h l=%b exp 0/0/0/0",
               bus.istream_ready, bus.ostream_valid,
               bus.ostream_data, bus.ostream_last);
    end
    checks++;
    if (bus.istream_buff_full !== 1'b0 ||
        bus.istream_buff_empty !== 1'b1 ||
        bus.istream_buff_afull !== 1'b0 ||
        bus.istream_buff_level !== '0) begin
      errors++;
      $display("FAIL reset_status f=%b e=%b af=%b lvl=%0d exp 0/1/0/0",
               bus.istream_buff_full, bus.istream_buff_empty,
               bus.istream_buff_afull, bus.istream_buff_level);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got=%b exp=0", bus.istream_ready);
    end
    tick();
    checks++;
    if (bus.istream_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got=%b exp=1", bus.istream_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] b [4];
    logic [WW:0] e0, e1;
    int maxlvl = 0;
    b[0] = 32'h11; b[1] = 32'h22; b[2] = 32'h33; b[3] = 32'h44;
    e0 = {1'b0, 32'h22, 32'h11};
    e1 = {1'b0, 32'h44, 32'h33};
    got.delete();
    bus.ostream_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.istream_valid = (i < 4);
      bus.istream_data  = (i < 4) ? b[i] : '0;
      bus.istream_last  = 1'b0;
      tick();
      if (int'(bus.istream_buff_level) > maxlvl)
        maxlvl = int'(bus.istream_buff_level);
    end
    bus.istream_valid = 1'b0;
    tick();
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=2", got.size());
    end else begin
      checks++;
      if (got[0] !== e0) begin
        errors++;
        $display("FAIL basic_word0 got=%h exp=%h", got[0], e0);
      end
      checks++;
      if (got[1] !== e1) begin
        errors++;
        $display("FAIL basic_word1 got=%h exp=%h", got[1], e1);
      end
    end
    checks++;
    if (maxlvl > 1) begin
      errors++;
      $display("FAIL basic_maxlevel got=%0d exp<=1", maxlvl);
    end
  endtask

  task automatic test_last();
    logic [WW:0] e0, e1;
    e0 = {1'b1, 32'h0, 32'hAA};
    e1 = {1'b0, 32'h02, 32'h01};
    got.delete();
    bus.ostream_ready = 1'b0;
    send(32'hAA, 1'b1);
    checks++;
    if (bus.ostream_valid !== 1'b1 || bus.ostream_last !== 1'b1 ||
        bus.ostream_data !== 64'hAA) begin
      errors++;
      $display("FAIL last_word v=%b l=%b d=%h exp 1/1/%h",
               bus.ostream_valid, bus.ostream_last,
               bus.ostream_data, 64'hAA);
    end
    send(32'h01, 1'b0);
    send(32'h02, 1'b0);
    checks++;
    if (bus.istream_buff_level !== LW'(2)) begin
      errors++;
      $display("FAIL last_level got=%0d exp=2", bus.istream_buff_level);
    end
    bus.ostream_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (got.size() != 2 || got[0] !== e0 || got[1] !== e1) begin
      errors++;
      $display("FAIL last_words n=%0d w0=%h w1=%h exp %h %h",
               got.size(), got.size() > 0 ? got[0] : '0,
               got.size() > 1 ? got[1] : '0, e0, e1);
    end
  endtask

  task automatic test_fill();
    int words;
    got.delete();
    popped.delete();
    bus.ostream_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(32'h100 + i, 1'b0);
      if (i % 2 == 1) begin
        words = (i + 1) / 2;
        checks++;
        if (bus.istream_buff_level !== LW'(words) ||
            bus.istream_buff_afull !== (words >= AF) ||
            bus.istream_buff_full !== (words == DEPTH)) begin
          errors++;
          $display("FAIL fill_status lvl=%0d af=%b f=%b exp %0d/%b/%b",
                   bus.istream_buff_level, bus.istream_buff_afull,
                   bus.istream_buff_full, words,
                   words >= AF, words == DEPTH);
        end
      end
    end
    checks++;
    if (bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready got=%b exp=0", bus.istream_ready);
    end
    bus.istream_valid = 1'b1;
    bus.istream_data  = 32'h200;
    repeat (3) tick();
    checks++;
    if (bus.istream_buff_level !== LW'(DEPTH) ||
        bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_hold lvl=%0d rdy=%b exp 8/0",
               bus.istream_buff_level, bus.istream_ready);
    end
  endtask

  task automatic test_full_pulse();
    logic [DW-1:0] b [18];
    logic [WW:0] e;
    for (int i = 0; i < 16; i++) b[i] = 32'h100 + i;
    b[16] = 32'h200;
    b[17] = 32'h201;
    bus.ostream_ready = 1'b1;
    tick();
    bus.ostream_ready = 1'b0;
    checks++;
    if (bus.istream_buff_level !== LW'(7) ||
        bus.istream_ready !== 1'b1) begin
      errors++;
      $display("FAIL pulse_pop lvl=%0d rdy=%b exp 7/1",
               bus.istream_buff_level, bus.istream_ready);
    end
    tick();
    bus.istream_data = 32'h201;
    tick();
    bus.istream_valid = 1'b0;
    checks++;
    if (bus.istream_buff_level !== LW'(8) ||
        bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL pulse_refill lvl=%0d rdy=%b exp 8/0",
               bus.istream_buff_level, bus.istream_ready);
    end
    bus.ostream_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (got.size() != 9) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=9", got.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        e = {1'b0, b[2*j+1], b[2*j]};
        checks++;
        if (got[j] !== e) begin
          errors++;
          $display("FAIL wrap_word%0d got=%h exp=%h", j, got[j], e);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [WW:0] e;
    e = {1'b0, 32'h402, 32'h401};
    got.delete();
    bus.ostream_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h300 + i, 1'b0);
    checks++;
    if (bus.istream_buff_level !== LW'(3)) begin
      errors++;
      $display("FAIL flush_pre lvl=%0d exp=3", bus.istream_buff_level);
    end
    bus.istream_flush = 1'b1;
    bus.istream_valid = 1'b1;
    bus.istream_data  = 32'h3FF;
    bus.ostream_ready = 1'b1;
    #1;
    checks++;
    if (bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got=%b exp=0", bus.istream_ready);
    end
    tick();
    bus.istream_flush = 1'b0;
    bus.istream_valid = 1'b0;
    bus.ostream_ready = 1'b0;
    #1;
    checks++;
    if (bus.istream_buff_level !== '0 ||
        bus.istream_buff_empty !== 1'b1 ||
        bus.ostream_valid !== 1'b0 || bus.ostream_data !== '0 ||
        bus.istream_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post lvl=%0d e=%b v=%b d=%h rdy=%b exp 0/1/0/0/1",
               bus.istream_buff_level, bus.istream_buff_empty,
               bus.ostream_valid, bus.ostream_data, bus.istream_ready);
    end
    send(32'h401, 1'b0);
    send(32'h402, 1'b0);
    checks++;
    if (bus.ostream_valid !== 1'b1 ||
        {bus.ostream_last, bus.ostream_data} !== e) begin
      errors++;
      $display("FAIL flush_newword v=%b d=%h exp 1/%h",
               bus.ostream_valid, {bus.ostream_last, bus.ostream_data}, e);
    end
    bus.ostream_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    logic [WW:0] e;
    e = {1'b0, 32'hC2, 32'hC1};
    bus.ostream_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h500 + i, 1'b0);
    checks++;
    if (bus.istream_buff_level !== LW'(5)) begin
      errors++;
      $display("FAIL arst_pre lvl=%0d exp=5", bus.istream_buff_level);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    pend.delete();
    out_of_rst = 1'b0;
    checks++;
    if (bus.istream_buff_level !== '0 ||
        bus.istream_buff_empty !== 1'b1 ||
        bus.istream_buff_full !== 1'b0 ||
        bus.istream_buff_afull !== 1'b0 ||
        bus.ostream_valid !== 1'b0 || bus.ostream_data !== '0 ||
        bus.ostream_last !== 1'b0 || bus.istream_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_out lvl=%0d e=%b f=%b af=%b v=%b d=%h rdy=%b",
               bus.istream_buff_level, bus.istream_buff_empty,
               bus.istream_buff_full, bus.istream_buff_afull,
               bus.ostream_valid, bus.ostream_data, bus.istream_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    got.delete();
    send(32'hC1, 1'b0);
    send(32'hC2, 1'b0);
    bus.ostream_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (got.size() != 1 || got[0] !== e) begin
      errors++;
      $display("FAIL arst_word n=%0d w=%h exp 1/%h",
               got.size(), got.size() > 0 ? got[0] : '0, e);
    end
  endtask

  task automatic test_random();
    bit er;
    got.delete();
    popped.delete();
    took = 1'b0;
    bus.istream_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.istream_valid || took) begin
        bus.istream_valid = ($urandom_range(0, 3) != 0);
        bus.istream_data  = $urandom;
        bus.istream_last  = ($urandom_range(0, 5) == 0);
      end
      bus.ostream_ready = (c < 200) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 3) != 0);
      bus.istream_flush = ($urandom_range(0, 49) == 0);
      tick();
      er = (bus.istream_buff_level !== LW'(exp_q.size())) ||
           (bus.ostream_valid !== (exp_q.size() > 0)) ||
           (bus.istream_buff_afull !== (exp_q.size() >= AF)) ||
           (bus.istream_ready !==
            ((exp_q.size() < DEPTH) && !bus.istream_flush));
      if (exp_q.size() > 0)
        er = er || ({bus.ostream_last, bus.ostream_data} !== exp_q[0]);
      checks++;
      if (er) begin
        errors++;
        $display("FAIL rand_cyc%0d lvl=%0d v=%b d=%h exp lvl=%0d head=%h",
                 c, bus.istream_buff_level, bus.ostream_valid,
                 {bus.ostream_last, bus.ostream_data}, exp_q.size(),
                 exp_q.size() > 0 ? exp_q[0] : '0);
      end
    end
    bus.istream_flush = 1'b0;
    bus.istream_valid = 1'b0;
    bus.ostream_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (got.size() != popped.size()) begin
      errors++;
      $display("FAIL rand_count got=%0d exp=%0d", got.size(), popped.size());
    end else begin
      for (int j = 0; j < got.size(); j++) begin
        checks++;
        if (got[j] !== popped[j]) begin
          errors++;
          $display("FAIL rand_word%0d got=%h exp=%h", j, got[j], popped[j]);
        end
      end
    end
  endtask

  initial begin
    bus.istream_valid = 1'b0;
    bus.istream_data  = '0;
    bus.istream_last  = 1'b0;
    bus.istream_flush = 1'b0;
    bus.ostream_ready = 1'b0;
    test_reset();
    test_basic();
    test_last();
    test_fill();
    test_full_pulse();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
